cfg_loader: RTL and testbench

- Upstream configuration stage for the xor cipher core.
- Collects a configuration frame from a byte-wide host port into a shadow register, then shifts it serially into the core over the cfg_en/cfg_i chain.
- Captures the core's previous configuration from cfg_o during the same shift, so the host can read it back byte by byte.
- Removes the need for the host to bit-bang the 67-cycle serial protocol.

---
 rtl/cfg_loader_if.sv | 23 ++
 rtl/cfg_loader.sv | 117 +++++++++++
 tb/tb_cfg_loader.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_loader_if.sv
// Host-side port bundle of cfg_loader: byte write channel, shift control/status
// and the combinational readback window.
interface cfg_loader_if;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       start;
   logic       busy;
   logic       done;
   logic       frame_full;
   logic [3:0] rb_sel;
   logic [7:0] rb_byte;

   modport master (
      output wr_valid, wr_data, start, rb_sel,
      input  wr_ready, busy, done, frame_full, rb_byte
   );

   modport slave (
      input  wr_valid, wr_data, start, rb_sel,
      output wr_ready, busy, done, frame_full, rb_byte
   );
endinterface

// File: rtl/cfg_loader.sv
// Loads a configuration frame byte-wise from the host, shifts it serially into the
// cipher core's cfg chain and captures the core's previous frame for readback.
module cfg_loader #(
   parameter int unsigned CFG_BITS = 67,
   parameter int unsigned NBYTES   = 9
) (
   input  logic         clk,
   input  logic         rst,
   cfg_loader_if.slave  host,
   output logic         cfg_en,
   output logic         cfg_i,
   input  logic         cfg_o
);

   localparam int unsigned BitW  = $clog2(CFG_BITS);
   localparam int unsigned ByteW = $clog2(NBYTES + 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e                r_state, w_state_nxt;
   logic [CFG_BITS-1:0]   r_shadow, w_shadow_nxt;
   logic [CFG_BITS-1:0]   r_readback, w_readback_nxt;
   logic [ByteW-1:0]      r_byte_cnt, w_byte_cnt_nxt;
   logic [BitW-1:0]       r_bit_cnt, w_bit_cnt_nxt;

   logic                  w_wr_ready;
   logic                  w_frame_full;
   logic                  w_wr_fire;
   logic                  w_last_bit;
   logic [7:0]            w_rb_byte;

   assign w_frame_full = (r_byte_cnt == ByteW'(NBYTES));
   assign w_wr_ready   = (r_state == StIdle) && (r_byte_cnt < ByteW'(NBYTES));
   assign w_wr_fire    = host.wr_valid && w_wr_ready;
   assign w_last_bit   = (r_bit_cnt == BitW'(CFG_BITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_shadow   <= '0;
         r_readback <= '0;
         r_byte_cnt <= '0;
         r_bit_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_shadow   <= w_shadow_nxt;
         r_readback <= w_readback_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_shadow_nxt   = r_shadow;
      w_readback_nxt = r_readback;
      w_byte_cnt_nxt = r_byte_cnt;
      w_bit_cnt_nxt  = r_bit_cnt;

      unique case (r_state)
         StIdle: begin
            if (w_wr_fire) begin
               // Bits of the last byte beyond the chain length have no home and drop.
               for (int k = 0; k < CFG_BITS; k++) begin
                  if (r_byte_cnt == ByteW'(k / 8)) begin
                     w_shadow_nxt[k] = host.wr_data[3'(k % 8)];
                  end
               end
               w_byte_cnt_nxt = r_byte_cnt + ByteW'(1);
            end
            // Uses frame_full from before this edge, so a same-cycle write cannot arm it.
            if (host.start && w_frame_full) begin
               w_state_nxt = StShift;
            end
         end

         StShift: begin
            w_shadow_nxt   = {1'b0, r_shadow[CFG_BITS-1:1]};
            w_readback_nxt = {cfg_o, r_readback[CFG_BITS-1:1]};
            w_bit_cnt_nxt  = r_bit_cnt + BitW'(1);
            if (w_last_bit) begin
               w_state_nxt = StDone;
            end
         end

         StDone: begin
            w_byte_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
            w_state_nxt    = StIdle;
         end

         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Readback window; selects past the last byte and bits past the chain read as 0.
   always_comb begin
      w_rb_byte = 8'h00;
      for (int k = 0; k < CFG_BITS; k++) begin
         if (host.rb_sel == 4'(k / 8)) begin
            w_rb_byte[3'(k % 8)] = r_readback[k];
         end
      end
   end

   assign host.wr_ready   = w_wr_ready;
   assign host.frame_full = w_frame_full;
   assign host.busy       = (r_state != StIdle);
   assign host.done       = (r_state == StDone);
   assign host.rb_byte    = w_rb_byte;

   assign cfg_en = (r_state == StShift);
   assign cfg_i  = (r_state == StShift) && r_shadow[0];

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader with a behavioural model of the core's cfg chain
// and frame-level expectations for shadow, core contents and readback.
module tb_cfg_loader;

   logic clk = 1'b0;
   logic rst;
   logic cfg_en, cfg_i, cfg_o;
   logic [66:0] core_q;

   always #5 clk = ~clk;

   cfg_loader_if hif ();

   cfg_loader #(
      .CFG_BITS (67),
      .NBYTES   (9)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .host   (hif),
      .cfg_en (cfg_en),
      .cfg_i  (cfg_i),
      .cfg_o  (cfg_o)
   );

   // Core's configuration chain: shifts in at the top, cfg_o is bit 0.
   always @(posedge clk) begin
      if (rst) core_q <= '0;
      else if (cfg_en) core_q <= {cfg_i, core_q[66:1]};
   end
   assign cfg_o = core_q[0];

   int n_tests = 0;
   int n_fail  = 0;

   // Frame-level model
   logic [71:0] frame_m;
   int          nb_m;
   logic [66:0] core_m;
   logic [66:0] rb_m;

   task automatic model_clear();
      frame_m = '0;
      nb_m    = 0;
      core_m  = '0;
      rb_m    = '0;
   endtask

   task automatic do_reset();
      hif.wr_valid = 1'b0;
      hif.start    = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic write_byte(input logic [7:0] d);
      if (nb_m < 9) begin
         frame_m[8*nb_m +: 8] = d;
         nb_m++;
      end
      hif.wr_valid = 1'b1;
      hif.wr_data  = d;
      @(negedge clk);
      hif.wr_valid = 1'b0;
   endtask

   task automatic load_random();
      for (int i = 0; i < 9; i++) write_byte(8'($urandom));
   endtask

   task automatic check_readback(input string name);
      logic [71:0] pad;
      logic [7:0]  exp;
      pad = {5'b0, rb_m};
      for (int sel = 0; sel < 16; sel++) begin
         hif.rb_sel = 4'(sel);
         #1;
         exp = (sel < 9) ? pad[8*sel +: 8] : 8'h00;
         n_tests++;
         if (hif.rb_byte !== exp) begin
            n_fail++;
            $display("FAIL %s rb_sel=%0d: got %02h expected %02h", name, sel, hif.rb_byte, exp);
         end
      end
      hif.rb_sel = 4'd0;
      @(negedge clk);
   endtask

   // Starts a shift and watches it cycle by cycle; cycle 0 is the cycle start is held.
   task automatic run_shift(input bit noise, input string name);
      logic [66:0] exp_stream;
      int en_cnt, first_en, last_en, done_cnt, done_cyc, busy_cnt, bad_bits;
      exp_stream = frame_m[66:0];
      en_cnt = 0; first_en = -1; last_en = -1;
      done_cnt = 0; done_cyc = -1; busy_cnt = 0; bad_bits = 0;
      hif.start = 1'b1;
      @(negedge clk);
      hif.start = 1'b0;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         if (cfg_en === 1'b1) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (cyc <= 67 && cfg_i !== exp_stream[cyc-1]) bad_bits++;
         end else if (cfg_i !== 1'b0) begin
            bad_bits++;
         end
         if (hif.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (hif.busy === 1'b1) busy_cnt++;
         if (noise && cyc <= 67) begin
            hif.wr_valid = 1'($urandom % 2);
            hif.wr_data  = 8'($urandom);
            hif.start    = 1'($urandom % 2);
         end else begin
            hif.wr_valid = 1'b0;
            hif.start    = 1'b0;
         end
         @(negedge clk);
      end
      hif.wr_valid = 1'b0;
      hif.start    = 1'b0;

      n_tests++;
      if (en_cnt != 67 || first_en != 1 || last_en != 67) begin
         n_fail++;
         $display("FAIL %s cfg_en window: got %0d cycles [%0d..%0d] expected 67 cycles [1..67]",
                  name, en_cnt, first_en, last_en);
      end
      n_tests++;
      if (done_cnt != 1 || done_cyc != 68) begin
         n_fail++;
         $display("FAIL %s done: got %0d pulses at cycle %0d expected 1 pulse at cycle 68",
                  name, done_cnt, done_cyc);
      end
      n_tests++;
      if (busy_cnt != 68) begin
         n_fail++;
         $display("FAIL %s busy cycles: got %0d expected 68", name, busy_cnt);
      end
      n_tests++;
      if (bad_bits != 0) begin
         n_fail++;
         $display("FAIL %s cfg_i stream: got %0d wrong bits expected 0", name, bad_bits);
      end

      rb_m    = core_m;
      core_m  = frame_m[66:0];
      frame_m = '0;
      nb_m    = 0;

      n_tests++;
      if (core_q !== core_m) begin
         n_fail++;
         $display("FAIL %s core frame: got %h expected %h", name, core_q, core_m);
      end
      n_tests++;
      if (hif.busy !== 1'b0 || hif.wr_ready !== 1'b1 || hif.frame_full !== 1'b0) begin
         n_fail++;
         $display("FAIL %s post-shift status: got busy=%b wr_ready=%b full=%b expected 0 1 0",
                  name, hif.busy, hif.wr_ready, hif.frame_full);
      end
      check_readback({name, " readback"});
   endtask

   task automatic test_reset();
      do_reset();
      repeat (5) @(negedge clk);
      n_tests++;
      if (hif.wr_ready !== 1'b1 || hif.busy !== 1'b0 || hif.done !== 1'b0 ||
          hif.frame_full !== 1'b0 || cfg_en !== 1'b0 || cfg_i !== 1'b0) begin
         n_fail++;
         $display("FAIL reset outputs: got rdy=%b busy=%b done=%b full=%b en=%b i=%b expected 1 0 0 0 0 0",
                  hif.wr_ready, hif.busy, hif.done, hif.frame_full, cfg_en, cfg_i);
      end
      check_readback("reset");
   endtask

   task automatic test_directed_frame();
      logic [7:0] bytes [9];
      bytes = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h60, 8'h00, 8'h00, 8'h00, 8'h05};
      do_reset();
      for (int i = 0; i < 9; i++) write_byte(bytes[i]);
      n_tests++;
      if (hif.frame_full !== 1'b1 || hif.wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL directed full: got full=%b wr_ready=%b expected 1 0",
                  hif.frame_full, hif.wr_ready);
      end
      run_shift(1'b0, "directed");
      n_tests++;
      if (core_q !== {3'b101, 32'h0000_0060, 32'h0000_0055}) begin
         n_fail++;
         $display("FAIL directed core literal: got %h expected %h", core_q,
                  {3'b101, 32'h0000_0060, 32'h0000_0055});
      end
   endtask

   task automatic test_partial_and_overflow();
      int bad;
      do_reset();
      for (int i = 0; i < 4; i++) write_byte(8'($urandom));
      n_tests++;
      if (hif.frame_full !== 1'b0 || hif.wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL partial status: got full=%b wr_ready=%b expected 0 1",
                  hif.frame_full, hif.wr_ready);
      end
      hif.start = 1'b1;
      @(negedge clk);
      hif.start = 1'b0;
      bad = 0;
      repeat (5) begin
         if (cfg_en !== 1'b0 || hif.busy !== 1'b0) bad++;
         @(negedge clk);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL early start: got %0d cycles active expected 0", bad);
      end
      for (int i = 4; i < 9; i++) write_byte(8'($urandom));
      n_tests++;
      if (hif.wr_ready !== 1'b0 || hif.frame_full !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow status: got wr_ready=%b full=%b expected 0 1",
                  hif.wr_ready, hif.frame_full);
      end
      write_byte(8'($urandom));
      run_shift(1'b0, "overflow");
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 8; i++) write_byte(8'($urandom));
      write_byte(8'hFF);
      run_shift(1'b0, "byte8 ff");
      n_tests++;
      if (core_q[66:64] !== 3'b111) begin
         n_fail++;
         $display("FAIL byte8 top bits: got %b expected 111", core_q[66:64]);
      end
      for (int i = 0; i < 9; i++) write_byte(8'hAA);
      run_shift(1'b0, "second frame");
   endtask

   task automatic test_reset_mid_shift();
      int bad;
      load_random();
      hif.start = 1'b1;
      @(negedge clk);
      hif.start = 1'b0;
      repeat (29) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (cfg_en !== 1'b0 || hif.busy !== 1'b0 || hif.done !== 1'b0 || hif.wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid-shift reset: got en=%b busy=%b done=%b rdy=%b expected 0 0 0 1",
                  cfg_en, hif.busy, hif.done, hif.wr_ready);
      end
      rst = 1'b0;
      model_clear();
      bad = 0;
      repeat (80) begin
         if (hif.done !== 1'b0 || cfg_en !== 1'b0) bad++;
         @(negedge clk);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL after abort: got %0d active cycles expected 0", bad);
      end
      check_readback("abort");
   endtask

   task automatic test_inputs_during_shift();
      for (int it = 0; it < 3; it++) begin
         load_random();
         run_shift(1'b1, "noisy shift");
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         load_random();
         run_shift(1'b0, "random");
      end
   endtask

   initial begin
      hif.wr_valid = 1'b0;
      hif.wr_data  = 8'h00;
      hif.start    = 1'b0;
      hif.rb_sel   = 4'd0;
      rst          = 1'b1;
      model_clear();
      test_reset();
      test_directed_frame();
      test_partial_and_overflow();
      test_back_to_back();
      test_reset_mid_shift();
      test_inputs_during_shift();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
